// File: rtl/ece429_fetch_buffer.sv
// rtl/ece429_fetch_buffer.sv - IF/ID buffer pairing fetch PCs with memory words, with skid and flush
module ece429_fetch_buffer (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] fetch_pc_in,
    input  logic        fetch_valid_in,
    input  logic [31:0] mem_data_in,
    input  logic        stall_in,
    input  logic        flush_in,
    output logic [31:0] pc_out,
    output logic [31:0] insn_out,
    output logic        valid_out,
    output logic        fetch_stall_out,
    output logic [15:0] squash_count_out
);

    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_insn_q, skid_insn_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insn_q, insn_d;
    logic [15:0] squash_q, squash_d;

    logic        hold;
    logic [16:0] squash_sum;

    assign hold            = valid_q & stall_in;
    assign fetch_stall_out = hold | skid_valid_q;
    assign pc_out           = pc_q;
    assign insn_out         = insn_q;
    assign valid_out        = valid_q;
    assign squash_count_out = squash_q;

    // At most two entries can be live at a flush, so a 17-bit sum is enough to detect overflow.
    assign squash_sum = {1'b0, squash_q} + {16'd0, valid_q} + {16'd0, skid_valid_q}
                      + {16'd0, pend_valid_q};

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_insn_d  = skid_insn_q;
        valid_d      = valid_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        squash_d     = squash_q;

        if (flush_in) begin
            valid_d      = 1'b0;
            pc_d         = 32'd0;
            insn_d       = 32'd0;
            skid_valid_d = 1'b0;
            pend_valid_d = 1'b0;
            squash_d     = squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
        end else begin
            if (!hold) begin
                if (skid_valid_q) begin
                    valid_d      = 1'b1;
                    pc_d         = skid_pc_q;
                    insn_d       = skid_insn_q;
                    skid_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    valid_d = 1'b1;
                    pc_d    = pend_pc_q;
                    insn_d  = mem_data_in;
                end else begin
                    valid_d = 1'b0;
                    pc_d    = 32'd0;
                    insn_d  = 32'd0;
                end
            end
            // The word already in flight when decode stalls has nowhere else to go.
            if (pend_valid_q && hold) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = pend_pc_q;
                skid_insn_d  = mem_data_in;
            end
            pend_valid_d = fetch_valid_in & ~fetch_stall_out;
            pend_pc_d    = fetch_pc_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_insn_q  <= 32'd0;
            valid_q      <= 1'b0;
            pc_q         <= 32'd0;
            insn_q       <= 32'd0;
            squash_q     <= 16'd0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_insn_q  <= skid_insn_d;
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            squash_q     <= squash_d;
        end
    end

endmodule
